knight_anim_ctrl: RTL and testbench
===================================

// Module: knight_anim_ctrl
// PURPOSE
// - Sequences the knight sprite ROMs (idle / walk / attack sheets, each SPR_W x SPR_H) for the VGA pipeline.
// - Animation FSM picks the active sheet and frame, stepped on the per-frame tick.
// - Per-pixel address generator maps DrawX/DrawY into a sheet address relative to the knight's
//   position, with horizontal flip for facing-left.
// - Sits between game logic (position, input requests) and the ROM/palette instances.
// PARAMETERS
// - SPR_W        50  sprite width in pixels
// - SPR_H        64  sprite height in pixels
// - WALK_FRAMES   4  frames in the walk cycle (wraps)
// - ATK_FRAMES    4  frames in the attack (one-shot)
// - TICKS_PER_FR  4  frame_tick pulses per animation frame
// PORTS
// - vga_clk      in   1   pixel clock; the only clock
// - Reset        in   1   asynchronous, active-high
// - frame_tick   in   1   one-cycle pulse, once per video frame (vsync edge)
// - attack_req   in   1   level; start an attack if not already attacking
// - move_left    in   1   level; walk left
// - move_right   in   1   level; walk right
// - DrawX,DrawY  in   10  current pixel coordinate
// - KnightX/Y    in   10  top-left sprite corner on screen
// - anim_sel     out  2   0=idle, 1=walk, 2=attack (selects ROM/palette mux)
// - frame_idx    out  2   current frame within the selected sheet
// - rom_address  out  12  address into the selected sheet
// - in_sprite    out  1   pixel lies inside the sprite box
// - facing_left  out  1   sprite is mirrored
// - attack_busy  out  1   high while the FSM is in ATTACK
// BEHAVIOUR
// - Reset values: FSM=IDLE, anim_sel=0, frame_idx=0, tick_cnt=0, facing_left=0,
//   rom_address=0, in_sprite=0, attack_busy=0. Reset mid-attack aborts to IDLE immediately.
// - FSM states: IDLE, WALK, ATTACK. Transitions are evaluated every vga_clk.
//   - IDLE/WALK + attack_req -> ATTACK. Set frame_idx=0 and tick_cnt=0. A frame_tick in the
//     same cycle is discarded.
//   - IDLE -> WALK when exactly one of move_left/move_right is high.
//   - WALK -> IDLE when neither or both are high.
//   - ATTACK: attack_req and move inputs are ignored (no queueing). On frame_tick with
//     tick_cnt==TICKS_PER_FR-1:
//     - if frame_idx==ATK_FRAMES-1, leave: go to WALK if exactly one move is held, else IDLE.
//       frame_idx=0.
//     - otherwise frame_idx+1.
// - Frame stepping: tick_cnt increments on frame_tick and wraps at TICKS_PER_FR-1.
//   - WALK: frame_idx advances on wrap, modulo WALK_FRAMES.
//   - IDLE: frame_idx held at 0.
//   - Any state change resets frame_idx and tick_cnt to 0.
// - facing_left updates only outside ATTACK: set by move_left alone, cleared by move_right
//   alone, held otherwise.
// - Address arithmetic uses 11-bit signed values: dx=DrawX-KnightX, dy=DrawY-KnightY.
//   - in_sprite = (0<=dx<SPR_W) && (0<=dy<SPR_H).
//   - col = facing_left ? SPR_W-1-dx : dx.
//   - rom_address = dy*SPR_W + col, truncated to 12 bits (max 3199).
//   - rom_address=0 when !in_sprite.
//   - Sprite partly off-screen (KnightX+SPR_W>639) clips naturally; no wrap.
// - Latency: rom_address/in_sprite are registered on posedge vga_clk, 1 cycle after DrawX/DrawY.
//   - The ROM samples on negedge and the palette is combinational, so pixel data is valid for
//     the next posedge colour register.
//   - Downstream must delay blank by the same 1 cycle.
// - anim_sel, frame_idx, facing_left and attack_busy are registered FSM outputs and change only
//   on the clock edge.
// STRUCTURE
// - knight_anim_pkg:
//   - anim_state_t enum {IDLE, WALK, ATTACK}, 2-bit; encoding equals anim_sel.
//   - localparams for default SPR_W/SPR_H and the address width.
// - Sub-module knight_sprite_addr: registered dx/dy, bounds check, flip and multiply-add.
//   Purely pixel-rate; takes facing_left as input.
// - The top holds the FSM, tick/frame counters and the facing register.
// TESTING
// - Reset during ATTACK frame 2 -> next cycle: anim_sel=0, frame_idx=0, attack_busy=0,
//   rom_address=0.
// - attack_req pulse from IDLE, 16 frame_ticks -> frame_idx steps 0,1,2,3 every 4 ticks.
//   After the 16th tick: anim_sel=0, attack_busy=0.
// - attack_req re-asserted mid-attack with move_right held -> attack is not restarted;
//   the FSM ends in WALK; facing_left is unchanged during the attack.
// - move_right held, 20 ticks -> frame_idx 0,1,2,3,0; move_left and move_right both high ->
//   IDLE with facing held.
// - KnightX=100, KnightY=200, facing right, DrawX=149, DrawY=263 -> one cycle later:
//   in_sprite=1, rom_address=3199.
//   - DrawX=150 -> in_sprite=0, rom_address=0.
// - Same position, facing_left=1, DrawX=100, DrawY=200 -> rom_address=49.
//   - KnightX=620, DrawX=639 -> in_sprite=1 (clipped, no wrap).

Source files
------------

// File: rtl/knight_anim_pkg.sv
// Shared types and default geometry for the knight sprite sequencer.
package knight_anim_pkg;

  // Encoding doubles as the ROM/palette select value.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    ATTACK = 2'd2
  } anim_state_t;

  localparam int SPR_W_DEF        = 50;
  localparam int SPR_H_DEF        = 64;
  localparam int WALK_FRAMES_DEF  = 4;
  localparam int ATK_FRAMES_DEF   = 4;
  localparam int TICKS_PER_FR_DEF = 4;

  localparam int ADDR_W  = 12;
  localparam int COORD_W = 10;
  localparam int FRAME_W = 2;
  localparam int TICK_W  = 2;

endpackage

// File: rtl/knight_sprite_addr.sv
// Pixel-rate address generator: maps the current draw coordinate to a sheet address
// relative to the knight corner, with optional horizontal mirroring. One cycle latency.
module knight_sprite_addr
  import knight_anim_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF
)(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [COORD_W-1:0] i_draw_x,
  input  logic [COORD_W-1:0] i_draw_y,
  input  logic [COORD_W-1:0] i_knight_x,
  input  logic [COORD_W-1:0] i_knight_y,
  input  logic               i_facing_left,
  output logic [ADDR_W-1:0]  o_rom_address,
  output logic               o_in_sprite
);

  logic signed [COORD_W:0] w_dx;
  logic signed [COORD_W:0] w_dy;
  logic [ADDR_W-1:0]       w_dx_u;
  logic [ADDR_W-1:0]       w_dy_u;
  logic [ADDR_W-1:0]       w_col;
  logic [ADDR_W-1:0]       w_row_base;
  logic [ADDR_W-1:0]       w_addr;
  logic                    w_in_sprite;

  assign w_dx = $signed({1'b0, i_draw_x}) - $signed({1'b0, i_knight_x});
  assign w_dy = $signed({1'b0, i_draw_y}) - $signed({1'b0, i_knight_y});

  // Unsigned views are only meaningful when the sign bit is clear, which the bounds check enforces.
  assign w_dx_u = {1'b0, w_dx};
  assign w_dy_u = {1'b0, w_dy};

  assign w_in_sprite = !w_dx[COORD_W] && (w_dx_u < ADDR_W'(SPR_W)) &&
                       !w_dy[COORD_W] && (w_dy_u < ADDR_W'(SPR_H));

  assign w_col      = i_facing_left ? (ADDR_W'(SPR_W - 1) - w_dx_u) : w_dx_u;
  assign w_row_base = w_dy_u * ADDR_W'(SPR_W);
  assign w_addr     = w_row_base + w_col;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rom_address <= '0;
      o_in_sprite   <= 1'b0;
    end else begin
      o_in_sprite   <= w_in_sprite;
      o_rom_address <= w_in_sprite ? w_addr : '0;
    end
  end

endmodule

// File: rtl/knight_anim_ctrl.sv
// Knight animation sequencer: picks sheet/frame from game inputs and drives the sprite ROM address.
//   state  | meaning
//   IDLE   | standing, frame 0
//   WALK   | exactly one direction held, frames cycle
//   ATTACK | one-shot swing, inputs ignored until last frame ends
module knight_anim_ctrl
  import knight_anim_pkg::*;
#(
  parameter int SPR_W        = SPR_W_DEF,
  parameter int SPR_H        = SPR_H_DEF,
  parameter int WALK_FRAMES  = WALK_FRAMES_DEF,
  parameter int ATK_FRAMES   = ATK_FRAMES_DEF,
  parameter int TICKS_PER_FR = TICKS_PER_FR_DEF
)(
  input  logic               i_vga_clk,
  input  logic               i_reset,
  input  logic               i_frame_tick,
  input  logic               i_attack_req,
  input  logic               i_move_left,
  input  logic               i_move_right,
  input  logic [COORD_W-1:0] i_draw_x,
  input  logic [COORD_W-1:0] i_draw_y,
  input  logic [COORD_W-1:0] i_knight_x,
  input  logic [COORD_W-1:0] i_knight_y,
  output logic [1:0]         o_anim_sel,
  output logic [FRAME_W-1:0] o_frame_idx,
  output logic [ADDR_W-1:0]  o_rom_address,
  output logic               o_in_sprite,
  output logic               o_facing_left,
  output logic               o_attack_busy
);

  anim_state_t        r_state;
  anim_state_t        w_state_nxt;
  logic [FRAME_W-1:0] r_frame_idx;
  logic [FRAME_W-1:0] w_frame_nxt;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [TICK_W-1:0]  w_tick_nxt;
  logic [TICK_W-1:0]  w_tick_inc;
  logic               r_facing_left;
  logic               w_facing_nxt;
  logic               w_one_move;
  logic               w_tick_last;

  assign w_one_move  = i_move_left ^ i_move_right;
  assign w_tick_last = (r_tick_cnt == TICK_W'(TICKS_PER_FR - 1));
  assign w_tick_inc  = w_tick_last ? '0 : r_tick_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame_idx;
    w_tick_nxt  = r_tick_cnt;
    case (r_state)
      IDLE: begin
        w_frame_nxt = '0;
        if (i_attack_req) begin
          w_state_nxt = ATTACK;
          w_tick_nxt  = '0;
        end else if (w_one_move) begin
          w_state_nxt = WALK;
          w_tick_nxt  = '0;
        end else if (i_frame_tick) begin
          w_tick_nxt = w_tick_inc;
        end
      end
      WALK: begin
        if (i_attack_req || !w_one_move) begin
          w_state_nxt = i_attack_req ? ATTACK : IDLE;
          w_frame_nxt = '0;
          w_tick_nxt  = '0;
        end else if (i_frame_tick) begin
          w_tick_nxt = w_tick_inc;
          if (w_tick_last)
            w_frame_nxt = (r_frame_idx == FRAME_W'(WALK_FRAMES - 1)) ? '0 : r_frame_idx + 1'b1;
        end
      end
      ATTACK: begin
        if (i_frame_tick) begin
          w_tick_nxt = w_tick_inc;
          if (w_tick_last) begin
            if (r_frame_idx == FRAME_W'(ATK_FRAMES - 1)) begin
              w_state_nxt = w_one_move ? WALK : IDLE;
              w_frame_nxt = '0;
            end else begin
              w_frame_nxt = r_frame_idx + 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_frame_nxt = '0;
        w_tick_nxt  = '0;
      end
    endcase
  end

  // Facing is frozen for the whole swing so the attack never flips mid-animation.
  always_comb begin
    w_facing_nxt = r_facing_left;
    if (r_state != ATTACK && w_one_move)
      w_facing_nxt = i_move_left;
  end

  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_frame_idx   <= '0;
      r_tick_cnt    <= '0;
      r_facing_left <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_idx   <= w_frame_nxt;
      r_tick_cnt    <= w_tick_nxt;
      r_facing_left <= w_facing_nxt;
    end
  end

  assign o_anim_sel    = r_state;
  assign o_frame_idx   = r_frame_idx;
  assign o_facing_left = r_facing_left;
  assign o_attack_busy = (r_state == ATTACK);

  knight_sprite_addr #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_sprite_addr (
    .i_clk         (i_vga_clk),
    .i_rst         (i_reset),
    .i_draw_x      (i_draw_x),
    .i_draw_y      (i_draw_y),
    .i_knight_x    (i_knight_x),
    .i_knight_y    (i_knight_y),
    .i_facing_left (r_facing_left),
    .o_rom_address (o_rom_address),
    .o_in_sprite   (o_in_sprite)
  );

endmodule

// File: tb/tb_knight_anim_ctrl.sv
// Directed bench for knight_anim_ctrl: FSM sequencing, facing, and sprite address generation.
module tb_knight_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, attack_req, move_left, move_right;
  logic [9:0] draw_x, draw_y, knight_x, knight_y;
  logic [1:0] anim_sel;
  logic [1:0] frame_idx;
  logic [11:0] rom_address;
  logic       in_sprite, facing_left, attack_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  knight_anim_ctrl dut (
    .i_vga_clk     (clk),
    .i_reset       (rst),
    .i_frame_tick  (frame_tick),
    .i_attack_req  (attack_req),
    .i_move_left   (move_left),
    .i_move_right  (move_right),
    .i_draw_x      (draw_x),
    .i_draw_y      (draw_y),
    .i_knight_x    (knight_x),
    .i_knight_y    (knight_y),
    .o_anim_sel    (anim_sel),
    .o_frame_idx   (frame_idx),
    .o_rom_address (rom_address),
    .o_in_sprite   (in_sprite),
    .o_facing_left (facing_left),
    .o_attack_busy (attack_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One frame_tick pulse spanning exactly one rising edge; returns on a falling edge.
  task automatic pulse_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pixel(input int x, input int y);
    @(negedge clk);
    draw_x = 10'(x);
    draw_y = 10'(y);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 0; attack_req = 0; move_left = 0; move_right = 0;
    draw_x = 0; draw_y = 0; knight_x = 10'd100; knight_y = 10'd200;
    idle_cycles(3);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_anim_sel", anim_sel, 0);
    check_eq("rst_frame", frame_idx, 0);
    check_eq("rst_busy", attack_busy, 0);
    check_eq("rst_facing", facing_left, 0);
    check_eq("rst_in_sprite", in_sprite, 0);
    check_eq("rst_rom", rom_address, 0);

    // single attack from IDLE
    attack_req = 1'b1;
    @(negedge clk) attack_req = 1'b0;
    check_eq("atk_sel", anim_sel, 2);
    check_eq("atk_busy", attack_busy, 1);
    check_eq("atk_frame0", frame_idx, 0);
    for (int t = 1; t <= 16; t++) begin
      pulse_tick();
      if (t < 16) check_eq($sformatf("atk_frame_t%0d", t), frame_idx, 32'(t / 4));
    end
    check_eq("atk_end_sel", anim_sel, 0);
    check_eq("atk_end_busy", attack_busy, 0);
    check_eq("atk_end_frame", frame_idx, 0);

    // walk left to set facing, then attack with re-request and move_right held
    move_left = 1'b1;
    idle_cycles(2);
    check_eq("walkl_sel", anim_sel, 1);
    check_eq("walkl_facing", facing_left, 1);
    move_left = 1'b0;
    attack_req = 1'b1;
    @(negedge clk) attack_req = 1'b0;
    move_right = 1'b1;
    check_eq("atk2_sel", anim_sel, 2);
    for (int t = 1; t <= 6; t++) pulse_tick();
    attack_req = 1'b1;
    @(negedge clk) attack_req = 1'b0;
    check_eq("atk2_norestart_frame", frame_idx, 1);
    check_eq("atk2_norestart_sel", anim_sel, 2);
    check_eq("atk2_facing_mid", facing_left, 1);
    for (int t = 7; t <= 16; t++) pulse_tick();
    check_eq("atk2_end_sel", anim_sel, 1);
    check_eq("atk2_end_frame", frame_idx, 0);
    check_eq("atk2_end_facing", facing_left, 1);
    @(negedge clk);
    check_eq("walkr_facing", facing_left, 0);

    // walk right for 20 ticks
    for (int t = 1; t <= 20; t++) begin
      pulse_tick();
      check_eq($sformatf("walk_frame_t%0d", t), frame_idx, 32'((t / 4) % 4));
    end
    move_left = 1'b1;
    @(negedge clk);
    check_eq("both_sel", anim_sel, 0);
    check_eq("both_frame", frame_idx, 0);
    check_eq("both_facing", facing_left, 0);
    move_left = 1'b0;
    move_right = 1'b0;

    // address, facing right
    set_pixel(149, 263);
    check_eq("addr_br_in", in_sprite, 1);
    check_eq("addr_br_rom", rom_address, 3199);
    set_pixel(150, 263);
    check_eq("addr_x_out_in", in_sprite, 0);
    check_eq("addr_x_out_rom", rom_address, 0);
    set_pixel(149, 264);
    check_eq("addr_y_out_in", in_sprite, 0);
    set_pixel(99, 200);
    check_eq("addr_neg_in", in_sprite, 0);
    set_pixel(100, 200);
    check_eq("addr_tl_in", in_sprite, 1);
    check_eq("addr_tl_rom", rom_address, 0);

    // reset during attack frame 2 with a live address
    set_pixel(149, 263);
    attack_req = 1'b1;
    @(negedge clk) attack_req = 1'b0;
    for (int t = 1; t <= 8; t++) pulse_tick();
    check_eq("pre_rst_frame", frame_idx, 2);
    check_eq("pre_rst_rom", rom_address, 3199);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_sel", anim_sel, 0);
    check_eq("mid_rst_frame", frame_idx, 0);
    check_eq("mid_rst_busy", attack_busy, 0);
    check_eq("mid_rst_rom", rom_address, 0);
    rst = 1'b0;
    idle_cycles(1);

    // facing left mirror
    move_left = 1'b1;
    @(negedge clk) move_left = 1'b0;
    @(negedge clk);
    check_eq("fl_facing", facing_left, 1);
    check_eq("fl_sel", anim_sel, 0);
    set_pixel(100, 200);
    check_eq("fl_tl_rom", rom_address, 49);
    set_pixel(149, 263);
    check_eq("fl_br_rom", rom_address, 3150);
    knight_x = 10'd620;
    set_pixel(639, 200);
    check_eq("clip_in", in_sprite, 1);
    check_eq("clip_rom", rom_address, 30);
    knight_x = 10'd1000;
    set_pixel(5, 200);
    check_eq("nowrap_in", in_sprite, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
